// File: rtl/ospi_pkg.sv
// Shared types and constants for the OSPI command sequencer.
package ospi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        WDATA,
        RDATA,
        GAP
    } state_t;

    localparam logic [7:0] OPC_RD_DEF = 8'h0B;
    localparam logic [7:0] OPC_WR_DEF = 8'h02;

    // phy_oe_o is active high (1 = we drive DQ); the PHY pin oeb is its inverse.
    localparam int TO_W = 16;

endpackage

// File: rtl/ospi_byte_cnt.sv
// Loadable down-counter with zero flag, shared by the address, dummy, data and gap phases.
module ospi_byte_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ospi_cmd_seq.sv
// OSPI command sequencer: opcode, address, dummy, then write data or read capture, with CS framing.
// Optional read timeout and timeout_o port enabled by defining OSPI_SEQ_RD_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a request, req_ready_o high
// CMD   | opcode byte to PHY
// ADDR  | address bytes, MSB first
// DUMMY | read turnaround, DQ released
// WDATA | write bytes passed through from wd_* to PHY
// RDATA | captured bytes forwarded to rd_*
// GAP   | CS low for CS_GAP cycles, done_o on first cycle
module ospi_cmd_seq
    import ospi_pkg::*;
#(
    parameter int         ADDR_BYTES   = 4,
    parameter int         DUMMY_CYCLES = 8,
    parameter int         LEN_W        = 8,
    parameter logic [7:0] OPC_RD       = OPC_RD_DEF,
    parameter logic [7:0] OPC_WR       = OPC_WR_DEF,
    parameter int         CS_GAP       = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_we_i,
    input  logic [31:0]      req_addr_i,
    input  logic [LEN_W-1:0] req_len_i,
    input  logic             wd_valid_i,
    output logic             wd_ready_o,
    input  logic [7:0]       wd_data_i,
    output logic             rd_valid_o,
    output logic [7:0]       rd_data_o,
    output logic             done_o,
    output logic             phy_valid_o,
    input  logic             phy_ready_i,
    output logic [7:0]       phy_data_o,
    output logic             phy_oe_o,
    output logic             cs_o,
    input  logic             phy_rx_valid_i,
    input  logic [7:0]       phy_rx_data_i,
    output logic             busy_o
`ifdef OSPI_SEQ_RD_TIMEOUT_EN
    ,output logic            timeout_o
`endif
);

    localparam int GAP_W  = $clog2(CS_GAP + 1);
    localparam int BASE_W = (LEN_W > 5) ? LEN_W : 5;
    localparam int CNT_W  = (BASE_W > GAP_W) ? BASE_W : GAP_W;

    state_t           state, state_n;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [LEN_W-1:0] len_q;
    logic             accept;
    logic             timeout_hit;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_val, cnt;
    logic [7:0]       addr_byte;

    ospi_byte_cnt #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    // Counter value in ADDR is the index of the byte still to send, so this walks MSB first.
    assign addr_byte = 8'(addr_q >> {cnt, 3'b000});

`ifdef OSPI_SEQ_RD_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;
`endif

    always_comb begin
        state_n     = state;
        accept      = 1'b0;
        timeout_hit = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        cnt_val     = '0;
        req_ready_o = 1'b0;
        wd_ready_o  = 1'b0;
        phy_valid_o = 1'b0;
        phy_oe_o    = 1'b0;
        phy_data_o  = 8'h00;
        case (state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    accept   = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(req_len_i);
                    state_n  = CMD;
                end
            end
            CMD: begin
                phy_valid_o = 1'b1;
                phy_oe_o    = 1'b1;
                phy_data_o  = we_q ? OPC_WR : OPC_RD;
                if (phy_ready_i) begin
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(ADDR_BYTES - 1);
                    state_n  = ADDR;
                end
            end
            ADDR: begin
                phy_valid_o = 1'b1;
                phy_oe_o    = 1'b1;
                phy_data_o  = addr_byte;
                if (phy_ready_i) begin
                    if (!cnt_zero) begin
                        cnt_dec = 1'b1;
                    end else if (we_q) begin
                        cnt_load = 1'b1;
                        cnt_val  = CNT_W'(len_q);
                        state_n  = WDATA;
                    end else if (DUMMY_CYCLES == 0) begin
                        cnt_load = 1'b1;
                        cnt_val  = CNT_W'(len_q);
                        state_n  = RDATA;
                    end else begin
                        cnt_load = 1'b1;
                        cnt_val  = CNT_W'(DUMMY_CYCLES - 1);
                        state_n  = DUMMY;
                    end
                end
            end
            DUMMY: begin
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(len_q);
                    state_n  = RDATA;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            WDATA: begin
                phy_valid_o = wd_valid_i;
                phy_oe_o    = 1'b1;
                phy_data_o  = wd_data_i;
                wd_ready_o  = phy_ready_i;
                if (wd_valid_i && phy_ready_i) begin
                    if (cnt_zero) begin
                        cnt_load = 1'b1;
                        cnt_val  = CNT_W'(CS_GAP - 1);
                        state_n  = GAP;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            RDATA: begin
                if (phy_rx_valid_i) begin
                    if (cnt_zero) begin
                        cnt_load = 1'b1;
                        cnt_val  = CNT_W'(CS_GAP - 1);
                        state_n  = GAP;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
`ifdef OSPI_SEQ_RD_TIMEOUT_EN
                else if (to_cnt == {{(TO_W-1){1'b1}}, 1'b0}) begin
                    timeout_hit = 1'b1;
                    cnt_load    = 1'b1;
                    cnt_val     = CNT_W'(CS_GAP - 1);
                    state_n     = GAP;
                end
`endif
            end
            GAP: begin
                if (cnt_zero)
                    state_n = IDLE;
                else
                    cnt_dec = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            cs_o       <= 1'b0;
            done_o     <= 1'b0;
            rd_valid_o <= 1'b0;
            rd_data_o  <= 8'h00;
        end else begin
            state      <= state_n;
            cs_o       <= (state_n != IDLE) && (state_n != GAP);
            done_o     <= (state_n == GAP) && (state != GAP);
            rd_valid_o <= (state == RDATA) && phy_rx_valid_i;
            if ((state == RDATA) && phy_rx_valid_i)
                rd_data_o <= phy_rx_data_i;
            if (accept) begin
                we_q   <= req_we_i;
                addr_q <= req_addr_i;
                len_q  <= req_len_i;
            end
        end
    end

`ifdef OSPI_SEQ_RD_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt    <= '0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= timeout_hit;
            if ((state != RDATA) || phy_rx_valid_i)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;
        end
    end
`endif

    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_ospi_cmd_seq.sv
// Self-checking bench for ospi_cmd_seq: vector table plus stall, reset, long-read and timeout sequences.
module tb_ospi_cmd_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic        wd_valid, wd_ready;
    logic [7:0]  wd_data;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        done, busy;
    logic        phy_valid, phy_ready, phy_oe, cs;
    logic [7:0]  phy_data;
    logic        rx_valid;
    logic [7:0]  rx_data;
`ifdef OSPI_SEQ_RD_TIMEOUT_EN
    logic        timeout;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ospi_cmd_seq dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_we_i       (req_we),
        .req_addr_i     (req_addr),
        .req_len_i      (req_len),
        .wd_valid_i     (wd_valid),
        .wd_ready_o     (wd_ready),
        .wd_data_i      (wd_data),
        .rd_valid_o     (rd_valid),
        .rd_data_o      (rd_data),
        .done_o         (done),
        .phy_valid_o    (phy_valid),
        .phy_ready_i    (phy_ready),
        .phy_data_o     (phy_data),
        .phy_oe_o       (phy_oe),
        .cs_o           (cs),
        .phy_rx_valid_i (rx_valid),
        .phy_rx_data_i  (rx_data),
        .busy_o         (busy)
`ifdef OSPI_SEQ_RD_TIMEOUT_EN
        ,.timeout_o     (timeout)
`endif
    );

    typedef struct {
        logic        rv, we;
        logic [31:0] a;
        logic [7:0]  l;
        logic        wv;
        logic [7:0]  wd;
        logic        pr, xv;
        logic [7:0]  xd;
        logic        e_rr, e_bz, e_cs, e_pv, e_oe;
        logic [7:0]  e_pd;
        logic        e_wr, e_dn, e_rdv;
        logic [7:0]  e_rdd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rv, we, input logic [31:0] a, input logic [7:0] l,
                                input logic wv, input logic [7:0] wd, input logic pr, xv,
                                input logic [7:0] xd, input logic rr, bz, cs_e, pv, oe,
                                input logic [7:0] pd, input logic wr, dn, rdv, input logic [7:0] rdd);
        vec_t v;
        v.rv = rv; v.we = we; v.a = a; v.l = l; v.wv = wv; v.wd = wd; v.pr = pr;
        v.xv = xv; v.xd = xd; v.e_rr = rr; v.e_bz = bz; v.e_cs = cs_e; v.e_pv = pv;
        v.e_oe = oe; v.e_pd = pd; v.e_wr = wr; v.e_dn = dn; v.e_rdv = rdv; v.e_rdd = rdd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 0; req_we = 0; req_addr = 0; req_len = 0;
        wd_valid = 0; wd_data = 0; phy_ready = 0; rx_valid = 0; rx_data = 0;
    endtask

    initial begin
        logic [7:0] exp_bytes[$];
        logic [7:0] prev_pd, prev_xd;
        logic       prev_stall, seen_done, bad_done;
        int         nrx, widx, npulse, extra, ncs;
        logic [31:0] wa, ra;

        idle_inputs();
        reset = 1;
        repeat (3) next_cycle();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_cs", cs, 0);
        chk("rst_oe", phy_oe, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_phy_valid", phy_valid, 0);
        chk("rst_rd_valid", rd_valid, 0);
        reset = 0;
        next_cycle();

        // ---- table: write 0x1234 len 3, then read 0xABCD0010 len 1 ----
        wa = 32'h0000_1234;
        ra = 32'hABCD_0010;
        tbl.push_back(mk(1,1,wa,3,1,8'h00,1,0,0, 1,0,0,0,0,8'h00,0,0,0,0));
        tbl.push_back(mk(0,1,wa,3,1,8'h00,1,0,0, 0,1,1,1,1,8'h02,0,0,0,0));
        tbl.push_back(mk(0,1,wa,3,1,8'h00,1,0,0, 0,1,1,1,1,8'h00,0,0,0,0));
        tbl.push_back(mk(0,1,wa,3,1,8'h00,1,0,0, 0,1,1,1,1,8'h00,0,0,0,0));
        tbl.push_back(mk(0,1,wa,3,1,8'h00,1,0,0, 0,1,1,1,1,8'h12,0,0,0,0));
        tbl.push_back(mk(0,1,wa,3,1,8'h00,1,0,0, 0,1,1,1,1,8'h34,0,0,0,0));
        tbl.push_back(mk(0,1,wa,3,1,8'hA0,1,0,0, 0,1,1,1,1,8'hA0,1,0,0,0));
        tbl.push_back(mk(0,1,wa,3,1,8'hA1,1,0,0, 0,1,1,1,1,8'hA1,1,0,0,0));
        tbl.push_back(mk(0,1,wa,3,1,8'hA2,1,0,0, 0,1,1,1,1,8'hA2,1,0,0,0));
        tbl.push_back(mk(0,1,wa,3,1,8'hA3,1,0,0, 0,1,1,1,1,8'hA3,1,0,0,0));
        tbl.push_back(mk(0,1,wa,3,1,8'h00,1,0,0, 0,1,0,0,0,8'h00,0,1,0,0));
        tbl.push_back(mk(0,1,wa,3,1,8'h00,1,0,0, 0,1,0,0,0,8'h00,0,0,0,0));
        tbl.push_back(mk(0,1,wa,3,0,8'h00,1,0,0, 1,0,0,0,0,8'h00,0,0,0,0));
        tbl.push_back(mk(1,0,ra,1,0,8'h00,1,0,0, 1,0,0,0,0,8'h00,0,0,0,0));
        tbl.push_back(mk(0,0,ra,1,0,8'h00,1,0,0, 0,1,1,1,1,8'h0B,0,0,0,0));
        tbl.push_back(mk(0,0,ra,1,0,8'h00,1,0,0, 0,1,1,1,1,8'hAB,0,0,0,0));
        tbl.push_back(mk(0,0,ra,1,0,8'h00,1,0,0, 0,1,1,1,1,8'hCD,0,0,0,0));
        tbl.push_back(mk(0,0,ra,1,0,8'h00,1,0,0, 0,1,1,1,1,8'h00,0,0,0,0));
        tbl.push_back(mk(0,0,ra,1,0,8'h00,1,0,0, 0,1,1,1,1,8'h10,0,0,0,0));
        for (int k = 0; k < 8; k++)   // dummy cycles; a stray rx in the middle must be ignored
            tbl.push_back(mk(0,0,ra,1,0,8'h00,1,(k == 4),8'h77, 0,1,1,0,0,8'h00,0,0,0,0));
        tbl.push_back(mk(0,0,ra,1,0,8'h00,1,1,8'h5A, 0,1,1,0,0,8'h00,0,0,0,0));
        tbl.push_back(mk(0,0,ra,1,0,8'h00,1,1,8'hC3, 0,1,1,0,0,8'h00,0,0,1,8'h5A));
        tbl.push_back(mk(0,0,ra,1,0,8'h00,1,0,8'h00, 0,1,0,0,0,8'h00,0,1,1,8'hC3));
        tbl.push_back(mk(0,0,ra,1,0,8'h00,1,0,8'h00, 0,1,0,0,0,8'h00,0,0,0,0));
        tbl.push_back(mk(0,0,ra,1,0,8'h00,1,0,8'h00, 1,0,0,0,0,8'h00,0,0,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            req_valid = tbl[i].rv; req_we = tbl[i].we; req_addr = tbl[i].a; req_len = tbl[i].l;
            wd_valid = tbl[i].wv; wd_data = tbl[i].wd; phy_ready = tbl[i].pr;
            rx_valid = tbl[i].xv; rx_data = tbl[i].xd;
            @(negedge clk);
            chk($sformatf("v%0d_req_ready", i), req_ready, tbl[i].e_rr);
            chk($sformatf("v%0d_busy", i), busy, tbl[i].e_bz);
            chk($sformatf("v%0d_cs", i), cs, tbl[i].e_cs);
            chk($sformatf("v%0d_phy_valid", i), phy_valid, tbl[i].e_pv);
            chk($sformatf("v%0d_phy_oe", i), phy_oe, tbl[i].e_oe);
            chk($sformatf("v%0d_wd_ready", i), wd_ready, tbl[i].e_wr);
            chk($sformatf("v%0d_done", i), done, tbl[i].e_dn);
            chk($sformatf("v%0d_rd_valid", i), rd_valid, tbl[i].e_rdv);
            if (tbl[i].e_pv)
                chk($sformatf("v%0d_phy_data", i), phy_data, tbl[i].e_pd);
            if (tbl[i].e_rdv)
                chk($sformatf("v%0d_rd_data", i), rd_data, tbl[i].e_rdd);
            next_cycle();
        end
        idle_inputs();
        next_cycle();

        // ---- 16-byte write with random PHY and write-data stalls ----
        exp_bytes = '{8'h02, 8'h00, 8'h00, 8'h01, 8'h00};
        for (int k = 0; k < 16; k++) exp_bytes.push_back(8'h10 + 8'(k));
        req_valid = 1; req_we = 1; req_addr = 32'h0000_0100; req_len = 8'd15;
        @(negedge clk);
        chk("stall_accept", req_ready, 1);
        next_cycle();
        req_valid = 0;
        nrx = 0; widx = 0; prev_stall = 0; prev_pd = 0; seen_done = 0;
        for (int cyc = 0; cyc < 3000 && !seen_done; cyc++) begin
            phy_ready = 1'($urandom_range(0, 1));
            wd_valid  = 1'($urandom_range(0, 1));
            wd_data   = (widx < 16) ? 8'h10 + 8'(widx) : 8'h00;
            @(negedge clk);
            if (phy_valid && prev_stall)
                chk("stall_hold", phy_data, prev_pd);
            if (phy_valid && phy_ready) begin
                if (nrx < exp_bytes.size())
                    chk($sformatf("stall_byte%0d", nrx), phy_data, exp_bytes[nrx]);
                nrx++;
            end
            if (wd_valid && wd_ready) widx++;
            prev_stall = phy_valid && !phy_ready;
            prev_pd    = phy_data;
            seen_done  = done;
            next_cycle();
        end
        chk("stall_done_seen", seen_done, 1);
        chk("stall_byte_count", nrx, exp_bytes.size());
        chk("stall_wd_count", widx, 16);
        idle_inputs();
        repeat (3) next_cycle();

        // ---- reset in the middle of WDATA ----
        req_valid = 1; req_we = 1; req_addr = 32'h0; req_len = 8'd3;
        phy_ready = 1; wd_valid = 1; wd_data = 8'h55;
        next_cycle();
        req_valid = 0;
        repeat (6) next_cycle();
        @(negedge clk);
        chk("rst_mid_in_wdata", wd_ready, 1);
        next_cycle();
        reset = 1;
        next_cycle();
        reset = 0; wd_valid = 0; phy_ready = 0;
        @(negedge clk);
        chk("rst_mid_cs", cs, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_req_ready", req_ready, 1);
        chk("rst_mid_busy", busy, 0);
        bad_done = 0;
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            @(negedge clk);
            if (done) bad_done = 1;
        end
        chk("rst_mid_no_done", bad_done, 0);
        next_cycle();

        // ---- 256-byte read, rx strobed every cycle (ignored outside RDATA) ----
        req_valid = 1; req_we = 0; req_addr = 32'h0; req_len = 8'hFF;
        phy_ready = 1; rx_valid = 1;
        npulse = 0; seen_done = 0; prev_xd = 0;
        for (int cyc = 0; cyc < 600 && !seen_done; cyc++) begin
            rx_data = 8'(cyc * 7 + 3);
            @(negedge clk);
            if (rd_valid) begin
                npulse++;
                if (npulse <= 4 || npulse >= 254)
                    chk($sformatf("long_rd_data%0d", npulse), rd_data, prev_xd);
            end
            seen_done = done;
            prev_xd = rx_data;
            next_cycle();
            req_valid = 0;
        end
        chk("long_done_seen", seen_done, 1);
        chk("long_pulses", npulse, 256);
        extra = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rd_valid) extra++;
            next_cycle();
        end
        chk("long_no_extra", extra, 0);
        idle_inputs();
        next_cycle();

`ifdef OSPI_SEQ_RD_TIMEOUT_EN
        // ---- read with no captured bytes must time out ----
        req_valid = 1; req_we = 0; req_addr = 32'h0; req_len = 8'd0; phy_ready = 1;
        ncs = 0; seen_done = 0;
        for (int cyc = 0; cyc < 70000 && !seen_done; cyc++) begin
            @(negedge clk);
            if (cs) ncs++;
            if (done) begin
                seen_done = 1;
                chk("to_pulse", timeout, 1);
            end else if (timeout) begin
                chk("to_early", timeout, 0);
            end
            next_cycle();
            req_valid = 0;
        end
        chk("to_done_seen", seen_done, 1);
        chk("to_cs_cycles", ncs, 1 + 4 + 8 + 65535);
        @(negedge clk);
        chk("to_pulse_width", timeout, 0);
        idle_inputs();
        next_cycle();
`else
        ncs = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
